// File: rtl/adc_reader.sv
// adc_reader: SPI frame reader for a dual-channel 14-bit ADC.
// Pulses AD_CONV, then clocks 34 SPI_SCK periods and captures two 14-bit
// two's-complement words, MSB first. The words are published on ch0/ch1
// together with a one-cycle valid pulse.
//
// Parameters:
//   SCK_DIV   qzt_clk cycles per SPI_SCK half-period (2..255)
// Ports:
//   qzt_clk   system clock, rising edge
//   reset     synchronous, active-high
//   start     level-sampled conversion request
//   SPI_MISO  serial data from the ADC
//   SPI_SCK   serial clock to the ADC, idles low
//   AD_CONV   conversion-start strobe to the ADC
//   ch0, ch1  last received channel samples, registered
//   valid     one-cycle pulse when ch0/ch1 update
//   busy      high while a frame is in progress
// Build option:
//   ADC_OFFSET_BINARY_EN  invert the received MSB (offset-binary output)
module adc_reader #(
    parameter int unsigned SCK_DIV = 4
) (
    input  logic        qzt_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        SPI_MISO,
    output logic        SPI_SCK,
    output logic        AD_CONV,
    output logic [13:0] ch0,
    output logic [13:0] ch1,
    output logic        valid,
    output logic        busy
);

    localparam int unsigned DATA_W = 14;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 6;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_RISE = BIT_W'(33);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic                start_q;
    logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic                half, half_nxt;
    logic [DATA_W-1:0]   sh0, sh0_nxt, sh1, sh1_nxt;
    logic [DATA_W-1:0]   ch0_nxt, ch1_nxt;
    logic                sck_nxt, conv_nxt, valid_nxt, busy_nxt;
    logic                div_tick;

    assign div_tick = (div_cnt == DIV_LAST);

    // Converts the shadow word into the published format.
    function automatic logic [DATA_W-1:0] fmt(input logic [DATA_W-1:0] raw);
`ifdef ADC_OFFSET_BINARY_EN
        return {~raw[DATA_W-1], raw[DATA_W-2:0]};
`else
        return raw;
`endif
    endfunction

    // State register and all datapath/output registers.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            half    <= 1'b0;
            sh0     <= '0;
            sh1     <= '0;
            ch0     <= '0;
            ch1     <= '0;
            SPI_SCK <= 1'b0;
            AD_CONV <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= start;
            div_cnt <= div_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            half    <= half_nxt;
            sh0     <= sh0_nxt;
            sh1     <= sh1_nxt;
            ch0     <= ch0_nxt;
            ch1     <= ch1_nxt;
            SPI_SCK <= sck_nxt;
            AD_CONV <= conv_nxt;
            valid   <= valid_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state, counters, capture and output decode.
    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        bit_cnt_nxt = bit_cnt;
        half_nxt    = half;
        sck_nxt     = SPI_SCK;
        sh0_nxt     = sh0;
        sh1_nxt     = sh1;
        ch0_nxt     = ch0;
        ch1_nxt     = ch1;

        case (state)
            IDLE: begin
                div_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                half_nxt    = 1'b0;
                sck_nxt     = 1'b0;
                if (start_q) state_nxt = CONV;
            end
            CONV: begin
                // Two divider periods of AD_CONV, tracked with the half flag.
                if (div_tick) begin
                    div_cnt_nxt = '0;
                    half_nxt    = ~half;
                    if (half) state_nxt = SHIFT;
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_tick) begin
                    div_cnt_nxt = '0;
                    sck_nxt     = ~SPI_SCK;
                    if (!SPI_SCK) begin
                        // Rising SCK edge: capture MISO into the proper shadow.
                        if (bit_cnt >= BIT_W'(2) && bit_cnt <= BIT_W'(15))
                            sh0_nxt = {sh0[DATA_W-2:0], SPI_MISO};
                        if (bit_cnt >= BIT_W'(18) && bit_cnt <= BIT_W'(31))
                            sh1_nxt = {sh1[DATA_W-2:0], SPI_MISO};
                    end else if (bit_cnt == LAST_RISE) begin
                        // Final falling edge: frame complete, publish words.
                        bit_cnt_nxt = '0;
                        state_nxt   = DONE;
                        ch0_nxt     = fmt(sh0);
                        ch1_nxt     = fmt(sh1);
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are registered copies of the upcoming state decode.
        conv_nxt  = (state_nxt == CONV);
        valid_nxt = (state_nxt == DONE);
        busy_nxt  = (state_nxt == CONV) || (state_nxt == SHIFT);
    end

endmodule
